// File: rtl/axi4lite_times_table_mem_if.sv
// AXI4-Lite port bundle for the times-table memory.
// The slave modport is the memory side; the master modport is the initiator side.
interface axi4lite_times_table_mem_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_times_table_mem.sv
// AXI4-Lite register memory preloaded with an a*b times table on every reset.
// AW and W are buffered independently; a write commits one edge after both are held.
module axi4lite_times_table_mem #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic s_aclk,
    input  logic s_aresetn,
    axi4lite_times_table_mem_if.slave s_axi
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HALF  = DEPTH_LOG2 / 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {AW_EMPTY, AW_HELD} aw_state_t;
    typedef enum logic {W_EMPTY, W_HELD} w_state_t;
    typedef enum logic {R_IDLE, R_VALID} r_state_t;

    // Upper index half is the row operand, lower half the column operand.
    function automatic logic [31:0] table_entry(input int unsigned idx);
        logic [DEPTH_LOG2-1:0] i_v;
        i_v = idx[DEPTH_LOG2-1:0];
        return 32'(i_v[DEPTH_LOG2-1:HALF]) * 32'(i_v[HALF-1:0]);
    endfunction

    logic [31:0] mem_r [0:DEPTH-1];

    aw_state_t   aw_state_r;
    w_state_t    w_state_r;
    r_state_t    r_state_r;
    logic [29:0] awaddr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;

    logic                  awready_s;
    logic                  wready_s;
    logic                  aw_in_range_s;
    logic [DEPTH_LOG2-1:0] aw_index_s;
    logic                  ar_in_range_s;
    logic [DEPTH_LOG2-1:0] ar_index_s;
    logic                  unused_addr_lsb_s;

    assign awready_s     = (aw_state_r == AW_EMPTY) && !bvalid_r;
    assign wready_s      = (w_state_r == W_EMPTY) && !bvalid_r;
    assign aw_in_range_s = (awaddr_r[29:DEPTH_LOG2] == '0);
    assign aw_index_s    = awaddr_r[DEPTH_LOG2-1:0];
    assign ar_in_range_s = (s_axi.araddr[31:DEPTH_LOG2+2] == '0);
    assign ar_index_s    = s_axi.araddr[DEPTH_LOG2+1:2];

    // Byte offsets within a word carry no meaning here.
    assign unused_addr_lsb_s = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = awready_s;
    assign s_axi.wready  = wready_s;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bresp   = bresp_r;
    assign s_axi.arready = (r_state_r == R_IDLE);
    assign s_axi.rvalid  = (r_state_r == R_VALID);
    assign s_axi.rdata   = rdata_r;
    assign s_axi.rresp   = rresp_r;

    // Write path: AW/W buffering, commit into the memory, and write response.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            aw_state_r <= AW_EMPTY;
            w_state_r  <= W_EMPTY;
            awaddr_r   <= 30'd0;
            wdata_r    <= 32'd0;
            wstrb_r    <= 4'd0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= table_entry(i);
            end
        end else if ((aw_state_r == AW_HELD) && (w_state_r == W_HELD)) begin
            aw_state_r <= AW_EMPTY;
            w_state_r  <= W_EMPTY;
            bvalid_r   <= 1'b1;
            if (aw_in_range_s) begin
                bresp_r <= RESP_OKAY;
                for (int l = 0; l < 4; l++) begin
                    if (wstrb_r[l]) begin
                        mem_r[aw_index_s][8*l +: 8] <= wdata_r[8*l +: 8];
                    end
                end
            end else begin
                bresp_r <= RESP_SLVERR;
            end
        end else begin
            if (bvalid_r && s_axi.bready) begin
                bvalid_r <= 1'b0;
            end
            if (s_axi.awvalid && awready_s) begin
                aw_state_r <= AW_HELD;
                awaddr_r   <= s_axi.awaddr[31:2];
            end
            if (s_axi.wvalid && wready_s) begin
                w_state_r <= W_HELD;
                wdata_r   <= s_axi.wdata;
                wstrb_r   <= s_axi.wstrb;
            end
        end
    end

    // Read path: a same-edge write commit is not yet visible, so reads see the old word.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state_r <= R_IDLE;
            rdata_r   <= 32'd0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        r_state_r <= R_VALID;
                        if (ar_in_range_s) begin
                            rdata_r <= mem_r[ar_index_s];
                            rresp_r <= RESP_OKAY;
                        end else begin
                            rdata_r <= 32'd0;
                            rresp_r <= RESP_SLVERR;
                        end
                    end
                end
                R_VALID: begin
                    if (s_axi.rready) begin
                        r_state_r <= R_IDLE;
                    end
                end
                default: r_state_r <= R_IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi4lite_times_table_mem.md
# axi4lite_times_table_mem

AXI4-Lite responder (slave) memory that holds a 0..7 x 0..7 times table and serves it to an AXI4-Lite initiator such as the multiplier front end. It provides a synthesizable, self-initialising replacement for the vendor block-RAM core behind the same 32-bit AXI4-Lite port set. Reads return table entries. Writes may overwrite entries until the next reset, which reloads the table.

## Interface
- DEPTH_LOG2, 6, log2 of word count; the entry index is {a[2:0], b[2:0]}.
- s_aclk  in  1  sole clock, rising edge.
- s_aresetn  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  32  write byte address.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte-lane enables; bit i enables wdata[8i+7:8i].
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  32  read byte address.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response, same encoding as bresp.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.

## Operation
- Storage is 2^DEPTH_LOG2 words of 32 bits, implemented as registers.
- On reset, word i is loaded with i[5:3]*i[2:0], zero-extended to 32 bits.
- Address decode:
  - Word index = addr[DEPTH_LOG2+1:2].
  - addr[1:0] is ignored.
  - An address is in range iff addr[31:DEPTH_LOG2+2] == 0. Any other address is out of range.
- Write path, states AW_EMPTY/AW_HELD and W_EMPTY/W_HELD, each buffered independently:
  - s_axi_awready = !aw_held && !s_axi_bvalid.
  - s_axi_wready = !w_held && !s_axi_bvalid.
  - AW and W may arrive in either order or in the same cycle.
  - When both are held, the write commits at the next edge:
    - In range: each byte lane with its strobe set is updated; other lanes keep their value.
    - Out of range: the memory is unchanged.
  - The same commit edge sets bvalid=1, sets bresp (OKAY if in range, SLVERR if out of range), and clears both buffers.
  - bvalid holds with bresp stable until bvalid && bready; it clears on that edge.
- Read path, states R_IDLE/R_VALID:
  - s_axi_arready = !s_axi_rvalid.
  - On the AR handshake edge:
    - In range: rdata <= mem[index] and rresp <= OKAY.
    - Out of range: rdata <= 0 and rresp <= SLVERR.
    - rvalid <= 1 in both cases.
  - rdata and rresp hold stable until rvalid && rready; rvalid clears on that edge.
- Simultaneous read and write commit to the same word on one edge: the read returns the pre-write value.
- The read and write paths are otherwise fully independent.

## Timing
- Reset values:
  - bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0.
  - AW and W buffers empty.
  - Memory reloaded with the table.
  - Consequently awready=1, wready=1, arready=1 while reset is asserted and after release.
- Reset asserted mid-transaction: all pending transactions are discarded immediately (asynchronous), and any uncommitted write is lost.
- Write latency: the last of the AW/W handshakes occurs at edge N; the commit and bvalid=1 occur at edge N+1.
- Write throughput: with bready held high, bvalid clears at N+2 and awready/wready return high after N+2. Maximum rate is one write per 3 cycles.
- Read latency: AR handshake at edge N gives rvalid=1 and valid rdata after N. With rready high, rvalid clears at N+1. Maximum rate is one read per 2 cycles.
- No combinational path from any input to any output except the ready outputs, which depend only on internal registers.

## Test plan
- After reset, read 0xB4 (a=5, b=5) -> rdata=25, rresp=00, rvalid one cycle after the AR handshake. Read 0xFC (a=7, b=7) -> 49. Read 0x1C (a=0, b=7) -> 0.
- Write 0xDEADBEEF to 0x08 with W presented 2 cycles before AW:
  - wready drops after the W handshake; awready stays high.
  - bvalid=1, bresp=00 one edge after the AW handshake.
  - Read 0x08 -> 0xDEADBEEF.
- Write 0xFFFF1234 with wstrb=4'b0011 to 0x0C (initial value 0) -> read returns 0x00001234.
- Read 0x100 -> rresp=10, rdata=0. Write 0xAA to 0x100 -> bresp=10. All 64 words are unchanged afterwards.
- Backpressure: hold rready=0 for 5 cycles after a read of 0xB4 -> rvalid=1, rdata=25 stable, arready=0 throughout. Hold bready=0 similarly -> bvalid stable, awready=wready=0.
- Reset mid-operation:
  - Write 0x99 to 0x28 (a=1, b=2).
  - Assert s_aresetn=0 while bvalid=1 -> bvalid=0 immediately.
  - After release, read 0x28 -> 2.
